// File: rtl/audio_dac_serializer_if.sv
// Sample-side inputs and I2S codec outputs of audio_dac_serializer.
// master = mixer/codec side, slave = the serializer itself.
interface audio_dac_serializer_if;
    // sample_req is a strobe, not a valid/ready handshake. The serializer
    // samples total_sound, gain_shift and mute on exactly the cycle it latches,
    // raises sample_req on the following cycle, and never waits on a ready.
    logic signed [31:0] total_sound;
    logic [3:0]         gain_shift;
    logic               mute;
    logic               AUD_BCLK;
    logic               AUD_DACLRCK;
    logic               AUD_DACDAT;
    logic               sample_req;
    logic               clip;

    modport master (
        output total_sound, gain_shift, mute,
        input  AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_req, clip
    );

    modport slave (
        input  total_sound, gain_shift, mute,
        output AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_req, clip
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// Latches, attenuates and saturates one 16-bit sample per frame and sends it
// as I2S on both slots. Optional soft mute fade: define AUDIO_SOFT_MUTE_EN.
module audio_dac_serializer #(
    parameter int BCLK_HALF = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    audio_dac_serializer_if.slave  aud
);
    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DW-1:0]      div_cnt;
    logic               bclk;
    logic [5:0]         bit_cnt;
    logic [5:0]         bit_next;
    logic [15:0]        sample_reg;
    logic               dat;
    logic               dat_next;
    logic               req;
    logic               clip_q;
    logic               div_wrap;
    logic               bclk_fall;
    logic               latch;
    logic [5:0]         eff_shift;
    logic               force_zero;
    logic signed [31:0] s1;
    logic [15:0]        sample_next;
    logic               clip_next;
    logic [3:0]         ser_idx;

    assign div_wrap  = (div_cnt == DW'(BCLK_HALF - 1));
    assign bclk_fall = div_wrap & bclk;
    assign latch     = bclk_fall & (bit_cnt == 6'd63);
    assign bit_next  = bit_cnt + 6'd1;

`ifdef AUDIO_SOFT_MUTE_EN
    logic [4:0] att;
    logic [4:0] att_next;

    always_comb begin
        att_next = att;
        if (aud.mute) begin
            if (att != 5'd16) att_next = att + 5'd1;
        end else begin
            if (att != 5'd0) att_next = att - 5'd1;
        end
    end

    // The sample latched on this event already uses the stepped attenuation.
    assign eff_shift  = {2'b00, aud.gain_shift} + {1'b0, att_next};
    assign force_zero = (att_next == 5'd16);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            att <= 5'd0;
        end else if (latch) begin
            att <= att_next;
        end
    end
`else
    assign eff_shift  = {2'b00, aud.gain_shift};
    assign force_zero = aud.mute;
`endif

    assign s1 = $signed(aud.total_sound) >>> eff_shift;

    always_comb begin
        sample_next = s1[15:0];
        clip_next   = 1'b0;
        if (s1 > 32'sd32767) begin
            sample_next = 16'h7FFF;
            clip_next   = 1'b1;
        end else if (s1 < -32'sd32768) begin
            sample_next = 16'h8000;
            clip_next   = 1'b1;
        end
        if (force_zero) begin
            sample_next = 16'h0000;
            clip_next   = 1'b0;
        end
    end

    // Slots 1..16 and 33..48 carry bits 15..0; 16 - slot modulo 16 picks the bit.
    assign ser_idx = 4'd0 - bit_next[3:0];

    always_comb begin
        dat_next = 1'b0;
        if ((bit_next >= 6'd1 && bit_next <= 6'd16) ||
            (bit_next >= 6'd33 && bit_next <= 6'd48)) begin
            dat_next = sample_reg[ser_idx];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            bit_cnt    <= 6'd0;
            sample_reg <= 16'h0000;
            dat        <= 1'b0;
            req        <= 1'b0;
            clip_q     <= 1'b0;
        end else begin
            req <= latch;
            if (div_wrap) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            if (bclk_fall) begin
                bit_cnt <= bit_next;
                dat     <= dat_next;
            end
            if (latch) begin
                sample_reg <= sample_next;
                clip_q     <= clip_next;
            end
        end
    end

    assign aud.AUD_BCLK    = bclk;
    assign aud.AUD_DACLRCK = bit_cnt[5];
    assign aud.AUD_DACDAT  = dat;
    assign aud.sample_req  = req;
    assign aud.clip        = clip_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: table vectors, random samples
// against a floor-division reference model, startup/reset timing and mute.
`timescale 1ns/1ps
module tb_audio_dac_serializer;
    localparam int BH    = 8;
    localparam int FRAME = 128 * BH;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #10 clk = ~clk;

    audio_dac_serializer_if aud ();

    audio_dac_serializer #(.BCLK_HALF(BH)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .aud      (aud)
    );

    typedef struct {
        logic signed [31:0] ts;
        logic [3:0]         gs;
        logic [15:0]        exp_s;
        logic               exp_c;
    } vec_t;

    vec_t        vecs[13];
    int          n_vec = 0;
    int          n_err = 0;
    int          model_att = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Attenuation as floor division by 2**shift, then clamping to int16.
    task automatic ref_model(input longint ts, input int gs, input bit mu,
                             output logic [15:0] s, output logic c);
        longint dv;
        longint q;
        int     sh;
        sh = gs;
`ifdef AUDIO_SOFT_MUTE_EN
        if (mu) model_att = (model_att < 16) ? model_att + 1 : 16;
        else    model_att = (model_att > 0)  ? model_att - 1 : 0;
        sh = gs + model_att;
        if (model_att == 16) begin
            s = 16'h0000;
            c = 1'b0;
            return;
        end
`else
        if (mu) begin
            s = 16'h0000;
            c = 1'b0;
            return;
        end
`endif
        dv = 64'sd1 << sh;
        q  = ts / dv;
        if (ts < 0 && q * dv != ts) q = q - 1;
        if (q > 32767) begin
            s = 16'h7FFF;
            c = 1'b1;
        end else if (q < -32768) begin
            s = 16'h8000;
            c = 1'b1;
        end else begin
            s = q[15:0];
            c = 1'b0;
        end
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        prev = aud.AUD_BCLK;
        ok   = 1'b0;
        for (int i = 0; i < 4 * BH; i++) begin
            @(negedge clk);
            if (aud.AUD_BCLK && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = aud.AUD_BCLK;
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (aud.sample_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Applies one sample, waits for its latch and deserializes the whole frame.
    task automatic run_frame(input logic signed [31:0] ts, input logic [3:0] gs, input bit mu,
                             input bit use_tab, input logic [15:0] tab_s, input logic tab_c,
                             input string name);
        logic [15:0] es;
        logic [15:0] left;
        logic [15:0] right;
        logic        ec;
        bit          ok;
        bit          tmo;
        int          lr_bad;
        int          zero_bad;
        aud.total_sound = ts;
        aud.gain_shift  = gs;
        aud.mute        = mu;
        wait_req(ok);
        check({name, "_req_seen"}, 32'(ok), 32'd1);
        if (!ok) return;
        ref_model(longint'(ts), int'(gs), mu, es, ec);
        if (use_tab) begin
            es = tab_s;
            ec = tab_c;
        end
        exp_q.push_back(es);
        @(negedge clk);
        check({name, "_req_width"}, 32'(aud.sample_req), 32'd0);
        check({name, "_clip"}, 32'(aud.clip), 32'(ec));
        left = 16'h0; right = 16'h0; lr_bad = 0; zero_bad = 0; tmo = 1'b0;
        for (int s = 0; s < 64; s++) begin
            wait_rise(ok);
            if (!ok) begin
                tmo = 1'b1;
                break;
            end
            if (aud.AUD_DACLRCK !== (s >= 32)) lr_bad++;
            if (s >= 1 && s <= 16)       left  = {left[14:0], aud.AUD_DACDAT};
            else if (s >= 33 && s <= 48) right = {right[14:0], aud.AUD_DACDAT};
            else if (aud.AUD_DACDAT !== 1'b0) zero_bad++;
            if (s == 30) begin
                aud.total_sound = $urandom();
                aud.gain_shift  = 4'($urandom_range(0, 15));
                aud.mute        = 1'($urandom_range(0, 1));
            end
            if (s == 50 && aud.clip !== ec) lr_bad++;
        end
        es = exp_q.pop_front();
        check({name, "_bclk_timeout"}, 32'(tmo), 32'd0);
        check({name, "_lrck_clip_hold"}, 32'(lr_bad), 32'd0);
        check({name, "_zero_slots"}, 32'(zero_bad), 32'd0);
        check({name, "_left"}, 32'(left), 32'(es));
        check({name, "_right"}, 32'(right), 32'(es));
    endtask

    // Must be entered on the negedge where reset was just released.
    task automatic check_startup(input string name);
        int first_bclk = 0;
        int first_lr   = 0;
        int lr_fall    = 0;
        int first_req  = 0;
        int dat_ones   = 0;
        for (int n = 1; n <= FRAME + 64; n++) begin
            @(negedge clk);
            if (first_bclk == 0 && aud.AUD_BCLK) first_bclk = n;
            if (first_lr == 0 && aud.AUD_DACLRCK) first_lr = n;
            if (first_lr != 0 && lr_fall == 0 && !aud.AUD_DACLRCK) lr_fall = n;
            if (first_req == 0 && aud.sample_req) first_req = n;
            if (n < FRAME + 2 * BH && aud.AUD_DACDAT) dat_ones++;
        end
        check({name, "_first_bclk"}, 32'(first_bclk), 32'(BH));
        check({name, "_lrck_rise"}, 32'(first_lr), 32'(64 * BH));
        check({name, "_lrck_fall"}, 32'(lr_fall), 32'(FRAME));
        check({name, "_first_req"}, 32'(first_req), 32'(FRAME));
        check({name, "_frame0_dat"}, 32'(dat_ones), 32'd0);
    endtask

    initial begin
        logic signed [31:0] ts;
        logic [15:0]        es;
        logic               ec;
        bit                 ok;

        vecs[0]  = '{32'sd1000,        4'd0,  16'h03E8, 1'b0};
        vecs[1]  = '{32'sd100000,      4'd0,  16'h7FFF, 1'b1};
        vecs[2]  = '{32'sd100000,      4'd4,  16'h186A, 1'b0};
        vecs[3]  = '{-32'sd70000,      4'd0,  16'h8000, 1'b1};
        vecs[4]  = '{-32'sd1,          4'd4,  16'hFFFF, 1'b0};
        vecs[5]  = '{32'sd32767,       4'd0,  16'h7FFF, 1'b0};
        vecs[6]  = '{32'sd32768,       4'd0,  16'h7FFF, 1'b1};
        vecs[7]  = '{-32'sd32768,      4'd0,  16'h8000, 1'b0};
        vecs[8]  = '{-32'sd32769,      4'd0,  16'h8000, 1'b1};
        vecs[9]  = '{-32'sd32769,      4'd1,  16'hBFFF, 1'b0};
        vecs[10] = '{32'sh7FFFFFFF,    4'd15, 16'h7FFF, 1'b1};
        vecs[11] = '{32'sh80000000,    4'd15, 16'h8000, 1'b1};
        vecs[12] = '{-32'sd5,          4'd1,  16'hFFFD, 1'b0};

        aud.total_sound = 32'sd0;
        aud.gain_shift  = 4'd0;
        aud.mute        = 1'b0;
        reset           = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({aud.AUD_BCLK, aud.AUD_DACLRCK, aud.AUD_DACDAT, aud.sample_req, aud.clip}), 32'd0);
        reset     = 1'b0;
        model_att = 0;
        check_startup("startup");

        for (int i = 0; i < 13; i++) begin
            run_frame(vecs[i].ts, vecs[i].gs, 1'b0, 1'b1, vecs[i].exp_s, vecs[i].exp_c,
                      $sformatf("vec%0d", i));
        end

`ifdef AUDIO_SOFT_MUTE_EN
        for (int k = 1; k <= 16; k++) begin
            run_frame(32'sd16384, 4'd0, 1'b1, 1'b1, (k == 16) ? 16'h0000 : 16'(16384 >> k), 1'b0,
                      $sformatf("fade_out%0d", k));
        end
        for (int j = 1; j <= 16; j++) begin
            run_frame(32'sd16384, 4'd0, 1'b0, 1'b1, (j == 1) ? 16'h0000 : 16'(16384 >> (16 - j)), 1'b0,
                      $sformatf("fade_in%0d", j));
        end
`else
        run_frame(32'sd16384, 4'd0, 1'b1, 1'b1, 16'h0000, 1'b0, "mute");
        run_frame(32'sd100000, 4'd0, 1'b1, 1'b1, 16'h0000, 1'b0, "mute_clip");
        run_frame(32'sd16384, 4'd0, 1'b0, 1'b1, 16'h4000, 1'b0, "unmute");
`endif

        for (int r = 0; r < 16; r++) begin
            case ($urandom_range(0, 2))
                0:       ts = $urandom();
                1:       ts = 32'($urandom_range(0, 131071)) - 32'sd65536;
                default: ts = 32'($urandom_range(0, 255)) - 32'sd128;
            endcase
            run_frame(ts, 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
                      1'b0, 16'h0, 1'b0, $sformatf("rand%0d", r));
        end

        aud.total_sound = 32'sd100000;
        aud.gain_shift  = 4'd0;
        aud.mute        = 1'b0;
        wait_req(ok);
        check("midreset_req_seen", 32'(ok), 32'd1);
        ref_model(64'sd100000, 0, 1'b0, es, ec);
        for (int s = 0; s <= 40; s++) begin
            wait_rise(ok);
            if (!ok) break;
        end
        check("midreset_slot40_dat", 32'(aud.AUD_DACDAT), 32'(es[8]));
        check("midreset_clip", 32'(aud.clip), 32'(ec));
        aud.total_sound = 32'sd0;
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outputs",
              32'({aud.AUD_BCLK, aud.AUD_DACLRCK, aud.AUD_DACDAT, aud.sample_req, aud.clip}), 32'd0);
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        model_att = 0;
        check_startup("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
